// File: rtl/beam_ctl_pkg.sv
// rtl/beam_ctl_pkg.sv - state codes, register map and ctl bit positions for beam_ctl
`timescale 1ns/1ps
package beam_ctl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARMED = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [2:0] ADDR_STEP  = 3'd0;
  localparam logic [2:0] ADDR_MOD   = 3'd1;
  localparam logic [2:0] ADDR_INIT  = 3'd2;
  localparam logic [2:0] ADDR_BURST = 3'd3;
  localparam logic [2:0] ADDR_CTL   = 3'd4;

  localparam int CTL_ARM   = 0;
  localparam int CTL_ABORT = 1;
  localparam int CTL_HALF  = 2;
  localparam int CTL_IMM   = 3;

endpackage

// File: rtl/beam_ctl_regs.sv
// rtl/beam_ctl_regs.sv - host shadow bank, active bank committed on arm, ctl strobe decode
`timescale 1ns/1ps
module beam_ctl_regs
  import beam_ctl_pkg::*;
#(
  parameter int CW = 12,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          lb_write,
  input  logic [2:0]    lb_addr,
  input  logic [15:0]   lb_data,
  input  logic          commit,
  output logic          arm_req,
  output logic          abort_req,
  output logic          imm_req,
  output logic [CW-1:0] phase_step,
  output logic [CW-1:0] modulo,
  output logic [CW-1:0] phase_init,
  output logic [NW-1:0] burst_len,
  output logic          half_rate
);

  logic          ctl_wr;
  logic [CW-1:0] sh_step;
  logic [CW-1:0] sh_mod;
  logic [CW-1:0] sh_init;
  logic [NW-1:0] sh_burst;

  assign ctl_wr    = lb_write && (lb_addr == ADDR_CTL);
  assign arm_req   = ctl_wr && lb_data[CTL_ARM];
  assign abort_req = ctl_wr && lb_data[CTL_ABORT];
  assign imm_req   = ctl_wr && lb_data[CTL_IMM];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_step  <= '0;
      sh_mod   <= '0;
      sh_init  <= '0;
      sh_burst <= '0;
    end else if (lb_write) begin
      case (lb_addr)
        ADDR_STEP:  sh_step  <= lb_data[CW-1:0];
        ADDR_MOD:   sh_mod   <= lb_data[CW-1:0];
        ADDR_INIT:  sh_init  <= lb_data[CW-1:0];
        ADDR_BURST: sh_burst <= lb_data[NW-1:0];
        default: ;
      endcase
    end
  end

  // commit only ever coincides with a ctl write, so half_rate comes straight from that write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_step <= '0;
      modulo     <= '0;
      phase_init <= '0;
      burst_len  <= '0;
      half_rate  <= 1'b0;
    end else if (commit) begin
      phase_step <= sh_step;
      modulo     <= sh_mod;
      phase_init <= sh_init;
      burst_len  <= sh_burst;
      half_rate  <= lb_data[CTL_HALF];
    end
  end

endmodule

// File: rtl/beam_ctl.sv
// rtl/beam_ctl.sv - beam pulser sequencer: run FSM, ena generator, burst gating and bunch count
`timescale 1ns/1ps
module beam_ctl
  import beam_ctl_pkg::*;
#(
  parameter int CW = 12,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          lb_write,
  input  logic [2:0]    lb_addr,
  input  logic [15:0]   lb_data,
  input  logic          trig,
  input  logic [CW-1:0] pulse_in,
  output logic          ena,
  output logic          bp_reset,
  output logic [CW-1:0] phase_step,
  output logic [CW-1:0] modulo,
  output logic [CW-1:0] phase_init,
  output logic [CW-1:0] pulse_out,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] bunches
);

  state_t        state;
  logic          arm_req;
  logic          abort_req;
  logic          imm_req;
  logic          commit;
  logic          half_rate;
  logic [NW-1:0] burst_len;
  logic [CW-1:0] pin_prev;
  logic          rise;
  logic          closing;

  assign commit   = arm_req && !abort_req && (state == ST_IDLE);
  assign rise     = (pulse_in != '0) && (pin_prev == '0);
  assign closing  = (burst_len != '0) && (bunches == burst_len) && (pulse_in == '0);
  assign bp_reset = (state != ST_RUN);
  assign busy     = (state == ST_ARMED) || (state == ST_LOAD) || (state == ST_RUN);

  beam_ctl_regs #(.CW(CW), .NW(NW)) u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .lb_write   (lb_write),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data),
    .commit     (commit),
    .arm_req    (arm_req),
    .abort_req  (abort_req),
    .imm_req    (imm_req),
    .phase_step (phase_step),
    .modulo     (modulo),
    .phase_init (phase_init),
    .burst_len  (burst_len),
    .half_rate  (half_rate)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ena <= 1'b1;
    else          ena <= half_rate ? ~ena : 1'b1;
  end

  // abort overrides every state and skips the tick work, so bunches keeps its value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pulse_out <= '0;
      done      <= 1'b0;
      bunches   <= '0;
      pin_prev  <= '0;
    end else begin
      done <= 1'b0;
      if (abort_req) begin
        state     <= ST_IDLE;
        pulse_out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            pulse_out <= '0;
            if (commit) begin
              bunches <= '0;
              state   <= imm_req ? ST_LOAD : ST_ARMED;
            end
          end
          ST_ARMED: if (ena && trig) state <= ST_LOAD;
          ST_LOAD: begin
            if (ena) begin
              pin_prev <= '0;
              state    <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (ena) begin
              pulse_out <= pulse_in;
              pin_prev  <= pulse_in;
              if (rise && (bunches != '1)) bunches <= bunches + NW'(1);
              if (closing) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            pulse_out <= '0;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beam_ctl.sv
// tb/tb_beam_ctl.sv - directed bench for beam_ctl with a phase-accumulator pulser model and gate scoreboard
`timescale 1ns/1ps
module tb_beam_ctl;
  import beam_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lb_write;
  logic [2:0]  lb_addr;
  logic [15:0] lb_data;
  logic        trig;
  logic [11:0] pulse_in;
  logic        ena;
  logic        bp_reset;
  logic [11:0] phase_step;
  logic [11:0] modulo;
  logic [11:0] phase_init;
  logic [11:0] pulse_out;
  logic        busy;
  logic        done;
  logic [15:0] bunches;

  int tests = 0;
  int fails = 0;
  int bad;

  logic [11:0] pin  = '0;
  logic [11:0] pend = '0;
  int          acc  = 0;
  int          m_v;
  int          nxt_v;
  int          r_v;

  logic [11:0] sb[$];
  logic [63:0] cen[$];
  int          r_sum;
  int          r_bun;
  int          r_done;
  bit          r_ok;

  beam_ctl #(.CW(12), .NW(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lb_write   (lb_write),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data),
    .trig       (trig),
    .pulse_in   (pulse_in),
    .ena        (ena),
    .bp_reset   (bp_reset),
    .phase_step (phase_step),
    .modulo     (modulo),
    .phase_init (phase_init),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .bunches    (bunches)
  );

  always #5 clk = ~clk;

  // pulser: on a wrap the residue r splits the bunch as (r, step-r) so its centroid is exact
  assign pulse_in = pin;
  always_comb begin
    m_v   = 4096 - int'(modulo);
    nxt_v = acc + int'(phase_step);
    r_v   = nxt_v - m_v;
  end
  always @(posedge clk) begin
    if (ena) begin
      if (bp_reset) begin
        acc  <= int'(phase_init);
        pin  <= '0;
        pend <= '0;
      end else if (nxt_v >= m_v) begin
        acc  <= r_v;
        pin  <= 12'(r_v);
        pend <= 12'(int'(phase_step) - r_v);
      end else begin
        acc  <= nxt_v;
        pin  <= pend;
        pend <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    lb_addr  = a;
    lb_data  = d;
    lb_write = 1'b1;
    @(negedge clk);
    lb_write = 1'b0;
  endtask

  // pulse_in seen before a RUN tick is pushed; pulse_out after that tick must match it
  task automatic run_loop(input int max_clk, input int stop_b);
    logic        p_tick;
    logic        p_run;
    logic [11:0] e;
    logic [63:0] numer;
    bit          inb;
    int          tail;
    sb.delete();
    cen.delete();
    r_sum = 0; r_bun = 0; r_done = 0; r_ok = 0;
    numer = '0; inb = 0; tail = -1;
    p_tick = ena;
    p_run  = ena && !bp_reset;
    if (p_run) sb.push_back(pulse_in);
    for (int n = 1; n <= max_clk; n++) begin
      @(negedge clk);
      if (p_run) begin
        e = sb.pop_front();
        chk("gate", 64'(pulse_out), 64'(e));
      end
      if (p_tick) begin
        r_sum += int'(pulse_out);
        if (pulse_out != '0) begin
          if (!inb) r_bun++;
          inb   = 1;
          numer = numer + 64'(pulse_out) * 64'(n);
        end else if (inb) begin
          cen.push_back(numer);
          numer = '0;
          inb   = 0;
        end
      end
      if (done) begin
        r_done++;
        if (tail < 0) tail = 5;
      end
      if (tail == 0 || (stop_b > 0 && r_bun == stop_b && !inb)) begin
        r_ok = 1;
        break;
      end
      if (tail > 0) tail--;
      p_tick = ena;
      p_run  = ena && !bp_reset;
      if (p_run) sb.push_back(pulse_in);
    end
    chk("run_timeout", 64'(r_ok), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; lb_write = 1'b0; lb_addr = '0; lb_data = '0; trig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ena", ena, 1);
    chk("rst_bp_reset", bp_reset, 1);
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bunches", bunches, 0);
    chk("rst_step", phase_step, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // immediate burst of 3
    wr(ADDR_STEP, 16'd13);
    wr(ADDR_MOD, 16'hFAD8);
    wr(ADDR_INIT, 16'd0);
    wr(ADDR_BURST, 16'd3);
    chk("shadow_isolated", phase_step, 0);
    wr(ADDR_CTL, 16'h9);
    chk("imm_busy", busy, 1);
    chk("imm_step", phase_step, 13);
    chk("imm_mod", modulo, 12'hAD8);
    chk("imm_load", bp_reset, 1);
    @(negedge clk);
    chk("imm_run", bp_reset, 0);
    run_loop(2000, 0);
    chk("b3_sum", r_sum, 39);
    chk("b3_bunches_seen", r_bun, 3);
    chk("b3_done_count", r_done, 1);
    chk("b3_bunches", bunches, 3);
    chk("b3_cen01", cen[1] - cen[0], 1320);
    chk("b3_cen12", cen[2] - cen[1], 1320);
    chk("b3_idle", busy, 0);

    // triggered start
    wr(ADDR_BURST, 16'd1);
    wr(ADDR_CTL, 16'h1);
    chk("trg_busy", busy, 1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bp_reset !== 1'b1 || pulse_out !== 12'd0) bad++;
    end
    chk("trg_armed_hold", bad, 0);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("trg_load", bp_reset, 1);
    @(negedge clk);
    chk("trg_run", bp_reset, 0);
    run_loop(1000, 0);
    chk("trg_sum", r_sum, 13);
    chk("trg_done_count", r_done, 1);
    chk("trg_bunches", bunches, 1);

    // half rate, triggered, trig on a non-tick edge first
    wr(ADDR_BURST, 16'd2);
    wr(ADDR_CTL, 16'h5);
    bad = 0;
    repeat (8) begin
      logic p;
      p = ena;
      @(negedge clk);
      if (ena === p) bad++;
    end
    chk("half_ena_toggle", bad, 0);
    for (int i = 0; i < 4 && ena !== 1'b0; i++) @(negedge clk);
    chk("half_find_nontick", ena, 0);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    chk("half_trig_ignored", bp_reset, 1);
    for (int i = 0; i < 4 && ena !== 1'b1; i++) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("half_load", bp_reset, 1);
    @(negedge clk);
    chk("half_load_hold", bp_reset, 1);
    @(negedge clk);
    chk("half_run", bp_reset, 0);
    run_loop(3000, 0);
    chk("half_sum", r_sum, 26);
    chk("half_done_count", r_done, 1);
    chk("half_bunches", bunches, 2);
    chk("half_cen01", cen[1] - cen[0], 2640);

    // continuous run with shadow write, ignored arm, then abort
    wr(ADDR_BURST, 16'd0);
    wr(ADDR_CTL, 16'h9);
    run_loop(1000, 2);
    wr(ADDR_STEP, 16'd20);
    chk("busy_step_held", phase_step, 13);
    wr(ADDR_CTL, 16'h1);
    chk("busy_arm_busy", busy, 1);
    chk("busy_arm_bunches", bunches, 2);
    chk("busy_arm_step", phase_step, 13);
    run_loop(1000, 3);
    wr(ADDR_CTL, 16'h2);
    chk("abort_busy", busy, 0);
    chk("abort_pulse_out", pulse_out, 0);
    chk("abort_bp_reset", bp_reset, 1);
    chk("abort_bunches", bunches, 5);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    chk("abort_no_done", bad, 0);
    chk("abort_bunches_hold", bunches, 5);

    // new arm picks up step 20, then reset mid-run in half rate
    wr(ADDR_CTL, 16'hD);
    chk("rearm_step", phase_step, 20);
    chk("rearm_bunches", bunches, 0);
    run_loop(3000, 1);
    chk("rearm_sum", r_sum, 20);
    for (int i = 0; i < 4 && ena !== 1'b0; i++) @(negedge clk);
    chk("mid_find_nontick", ena, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ena", ena, 1);
    chk("mid_rst_bp_reset", bp_reset, 1);
    chk("mid_rst_pulse_out", pulse_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bunches", bunches, 0);
    chk("mid_rst_step", phase_step, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ena", ena, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
